// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if
//   Bundles the store-request, load-request and data-memory port signals
//   of the posted-write store buffer into one interface.
//
//   Store side : st_valid, st_type, st_addr, st_data -> st_ready, st_err
//   Load side  : ld_valid, ld_addr                   -> ld_stall, ld_data
//   Memory     : dm_a, dm_be, dm_wd, dm_we           <- dm_rd
//   Status     : empty, count
//
//   Modports:
//     slave  - the store buffer itself
//     master - the environment (pipeline MEM stage plus data memory)
interface dm_store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // store request
    logic          st_valid;
    logic [1:0]    st_type;
    logic [12:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_err;

    // load request
    logic          ld_valid;
    logic [12:0]   ld_addr;
    logic          ld_stall;
    logic [31:0]   ld_data;

    // data memory port
    logic [10:0]   dm_a;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wd;
    logic          dm_we;
    logic [31:0]   dm_rd;

    // status
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  st_valid, st_type, st_addr, st_data,
        input  ld_valid, ld_addr,
        input  dm_rd,
        output st_ready, st_err,
        output ld_stall, ld_data,
        output dm_a, dm_be, dm_wd, dm_we,
        output empty, count
    );

    modport master (
        output st_valid, st_type, st_addr, st_data,
        output ld_valid, ld_addr,
        output dm_rd,
        input  st_ready, st_err,
        input  ld_stall, ld_data,
        input  dm_a, dm_be, dm_wd, dm_we,
        input  empty, count
    );
endinterface

// File: rtl/dm_store_buffer.sv
// dm_store_buffer
//   Posted-write store buffer sitting between the MEM-stage store/load logic
//   and an 8 KB word-addressed data memory with a single address port.
//   Word/halfword/byte stores are queued (word address, byte enables, raw
//   low-aligned data) and drained one per cycle. A load that does not hit a
//   pending store takes the memory port; a load that hits any pending store
//   to the same word stalls and forces draining until the hit clears.
//
//   Ports:
//     clk    - clock, all state updates on the rising edge
//     reset  - asynchronous active-high reset, discards every pending store
//     bus    - dm_store_buffer_if.slave (store, load, memory and status signals)
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_store_buffer_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [10:0]   addr_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          st_err_reg, st_err_next;

    // ------------------------------------------------------------------
    // Store decode: byte enables and alignment check
    // ------------------------------------------------------------------
    logic [3:0] push_be;
    logic       misaligned;
    logic       full;
    logic       push;
    logic       pop;

    always_comb begin
        push_be    = 4'b0000;
        misaligned = 1'b0;
        case (bus.st_type)
            2'b00: begin
                push_be    = 4'b1111;
                misaligned = (bus.st_addr[1:0] != 2'b00);
            end
            2'b01: begin
                push_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = bus.st_addr[0];
            end
            2'b10: begin
                push_be    = 4'b0001 << bus.st_addr[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Readiness only looks at the current occupancy; a pop in the same
    // cycle does not make room for a push until the following cycle.
    assign full = (count_reg == CW'(DEPTH));
    assign push = bus.st_valid && !full && !misaligned;

    // ------------------------------------------------------------------
    // Load hit detection against every occupied entry
    // ------------------------------------------------------------------
    // An entry is occupied when its distance from the head (modulo DEPTH)
    // is below the count. A store being pushed this very cycle is not yet
    // in the array, so it is naturally excluded from the comparison.
    logic [DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PW-1:0] age;
            logic          occupied;
            assign age          = PW'(gi) - head_reg;
            assign occupied     = ({1'b0, age} < count_reg);
            assign match[gi]    = occupied && (addr_mem[gi] == bus.ld_addr[12:2]);
        end
    endgenerate

    logic hit;
    logic load_port;
    logic [1:0] ld_offset_unused;

    assign ld_offset_unused = bus.ld_addr[1:0];
    assign hit       = bus.ld_valid && (|match);
    assign load_port = bus.ld_valid && !hit;

    // ------------------------------------------------------------------
    // Memory port arbitration
    // ------------------------------------------------------------------
    // A non-hitting load owns the port and drain pauses; otherwise the head
    // entry is presented and written whenever anything is pending. Because
    // count clears asynchronously, dm_we drops the moment reset asserts.
    assign bus.dm_we    = !load_port && (count_reg != '0);
    assign bus.dm_a     = load_port ? bus.ld_addr[12:2] : addr_mem[head_reg];
    assign bus.dm_be    = bus.dm_we ? be_mem[head_reg] : 4'b0000;
    assign bus.dm_wd    = data_mem[head_reg];
    assign pop          = bus.dm_we;

    assign bus.ld_stall = hit;
    assign bus.ld_data  = bus.dm_rd;
    assign bus.st_ready = !full;
    assign bus.st_err   = st_err_reg;
    assign bus.empty    = (count_reg == '0);
    assign bus.count    = count_reg;

    // ------------------------------------------------------------------
    // Pointer / count update
    // ------------------------------------------------------------------
    always_comb begin
        head_next   = head_reg;
        tail_next   = tail_reg;
        count_next  = count_reg;
        st_err_next = bus.st_valid && misaligned;
        if (push) begin
            tail_next = tail_reg + PW'(1);
        end
        if (pop) begin
            head_next = head_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            st_err_reg <= 1'b0;
        end else begin
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            count_reg  <= count_next;
            st_err_reg <= st_err_next;
        end
    end

    // Entry payload needs no reset: occupancy is defined purely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= bus.st_addr[12:2];
            be_mem[tail_reg]   <= push_be;
            data_mem[tail_reg] <= bus.st_data;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic mem_clear;

    dm_store_buffer_if #(.DEPTH(DEPTH)) bus ();

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Data memory model: word-addressed, lane placement derived from BE
    // (write data arrives low-aligned). Unwritten words read a known pattern.
    // ------------------------------------------------------------------
    logic [31:0]   mem [2048];
    logic [2047:0] written;

    function automatic logic [31:0] init_word(input logic [10:0] a);
        return (a == 11'd4) ? 32'h0000_0000 : {16'h5A5A, 5'b0, a};
    endfunction

    assign bus.dm_rd = written[bus.dm_a] ? mem[bus.dm_a] : init_word(bus.dm_a);

    always @(posedge clk) begin : mem_write
        logic [31:0] w;
        logic [31:0] sh;
        if (mem_clear) begin
            written <= '0;
        end else if (bus.dm_we) begin
            casez (bus.dm_be)
                4'b???1: sh = bus.dm_wd;
                4'b??10: sh = bus.dm_wd << 8;
                4'b?100: sh = bus.dm_wd << 16;
                default: sh = bus.dm_wd << 24;
            endcase
            w = bus.dm_rd;
            for (int b = 0; b < 4; b++)
                if (bus.dm_be[b]) w[8*b +: 8] = sh[8*b +: 8];
            mem[bus.dm_a]     <= w;
            written[bus.dm_a] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        st_valid;
        logic [1:0]  st_type;
        logic [12:0] st_addr;
        logic [31:0] st_data;
        logic        ld_valid;
        logic [12:0] ld_addr;
        logic        e_ready;
        logic        e_err;
        logic        e_stall;
        logic        e_we;
        logic        chk_a;
        logic [10:0] e_a;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [2:0]  e_count;
        logic        chk_ld;
        logic [31:0] e_ld;
    } vec_t;

    function automatic vec_t mk(
        input logic sv, input logic [1:0] ty, input logic [12:0] sa, input logic [31:0] sd,
        input logic lv, input logic [12:0] la,
        input logic rdy, input logic err, input logic stl, input logic we,
        input logic ca, input logic [10:0] a, input logic [3:0] be, input logic [31:0] wd,
        input logic [2:0] cnt, input logic cl, input logic [31:0] ld);
        vec_t v;
        v.st_valid = sv;  v.st_type = ty;  v.st_addr = sa;  v.st_data = sd;
        v.ld_valid = lv;  v.ld_addr = la;
        v.e_ready  = rdy; v.e_err   = err; v.e_stall = stl; v.e_we = we;
        v.chk_a    = ca;  v.e_a     = a;   v.e_be    = be;  v.e_wd = wd;
        v.e_count  = cnt; v.chk_ld  = cl;  v.e_ld    = ld;
        return v;
    endfunction

    task automatic drive(input logic sv, input logic [1:0] ty, input logic [12:0] sa,
                         input logic [31:0] sd, input logic lv, input logic [12:0] la);
        bus.st_valid = sv; bus.st_type = ty; bus.st_addr = sa; bus.st_data = sd;
        bus.ld_valid = lv; bus.ld_addr = la;
    endtask

    vec_t vq[$];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        // --------------------------------------------------------------
        // Vector table
        // --------------------------------------------------------------
        // four word stores back to back, no loads
        vq.push_back(mk(1,2'b00,13'h000,32'h11, 0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0,  3'd0, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h004,32'h22, 0,13'h0, 1,0,0,1, 1,11'h0,4'hF,32'h11, 3'd1, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h008,32'h33, 0,13'h0, 1,0,0,1, 1,11'h1,4'hF,32'h22, 3'd1, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h00C,32'h44, 0,13'h0, 1,0,0,1, 1,11'h2,4'hF,32'h33, 3'd1, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h0, 1,0,0,1, 1,11'h3,4'hF,32'h44, 3'd1, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0,  3'd0, 0,32'h0));
        // non-hitting load held while pushing five stores, then drain
        vq.push_back(mk(1,2'b00,13'h020,32'hA0, 1,13'h100, 1,0,0,0, 1,11'h40,4'h0,32'h0, 3'd0, 1,32'h5A5A0040));
        vq.push_back(mk(1,2'b00,13'h024,32'hA1, 1,13'h100, 1,0,0,0, 1,11'h40,4'h0,32'h0, 3'd1, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h028,32'hA2, 1,13'h100, 1,0,0,0, 1,11'h40,4'h0,32'h0, 3'd2, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h02C,32'hA3, 1,13'h100, 1,0,0,0, 1,11'h40,4'h0,32'h0, 3'd3, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h030,32'hA4, 1,13'h100, 0,0,0,0, 1,11'h40,4'h0,32'h0, 3'd4, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h000, 0,0,0,1, 1,11'h08,4'hF,32'hA0, 3'd4, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h000, 1,0,0,1, 1,11'h09,4'hF,32'hA1, 3'd3, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h000, 1,0,0,1, 1,11'h0A,4'hF,32'hA2, 3'd2, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h000, 1,0,0,1, 1,11'h0B,4'hF,32'hA3, 3'd1, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,  0,13'h000, 1,0,0,0, 0,11'h0,4'h0,32'h0,   3'd0, 0,32'h0));
        // sb @0x013, sh @0x012 alongside lw @0x010 -> stall until both retire
        vq.push_back(mk(1,2'b10,13'h013,32'hAB,   0,13'h000, 1,0,0,0, 0,11'h0,4'h0,32'h0,      3'd0, 0,32'h0));
        vq.push_back(mk(1,2'b01,13'h012,32'hCDEF, 1,13'h010, 1,0,1,1, 1,11'h4,4'b1000,32'hAB,  3'd1, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    1,13'h010, 1,0,1,1, 1,11'h4,4'b1100,32'hCDEF,3'd1, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    1,13'h010, 1,0,0,0, 1,11'h4,4'h0,32'h0,      3'd0, 1,32'hCDEF0000));
        // misaligned / illegal stores: no push, one-cycle error pulse
        vq.push_back(mk(1,2'b01,13'h001,32'h1234, 0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    0,13'h0, 1,1,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(1,2'b00,13'h006,32'h5678, 0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    0,13'h0, 1,1,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(1,2'b11,13'h000,32'h9ABC, 0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    0,13'h0, 1,1,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));
        vq.push_back(mk(0,2'b00,13'h000,32'h0,    0,13'h0, 1,0,0,0, 0,11'h0,4'h0,32'h0, 3'd0, 0,32'h0));

        // --------------------------------------------------------------
        // Reset state (load requested during reset must not stall)
        // --------------------------------------------------------------
        reset     = 1'b1;
        mem_clear = 1'b1;
        drive(0, 2'b00, 13'h000, 32'h0, 1, 13'h040);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_count",    0, 32'(bus.count),    32'd0);
        chk("rst_empty",    0, 32'(bus.empty),    32'd1);
        chk("rst_st_ready", 0, 32'(bus.st_ready), 32'd1);
        chk("rst_st_err",   0, 32'(bus.st_err),   32'd0);
        chk("rst_dm_we",    0, 32'(bus.dm_we),    32'd0);
        chk("rst_ld_stall", 0, 32'(bus.ld_stall), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_clear = 1'b0;
        drive(0, 2'b00, 13'h000, 32'h0, 0, 13'h000);

        // --------------------------------------------------------------
        // Apply vector table
        // --------------------------------------------------------------
        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            drive(vq[i].st_valid, vq[i].st_type, vq[i].st_addr, vq[i].st_data,
                  vq[i].ld_valid, vq[i].ld_addr);
            #3;
            $display("vec %0d: st_v=%0b ld_v=%0b we=%0b a=%03h be=%b wd=%08h cnt=%0d stall=%0b err=%0b",
                     i, vq[i].st_valid, vq[i].ld_valid, bus.dm_we, bus.dm_a, bus.dm_be,
                     bus.dm_wd, bus.count, bus.ld_stall, bus.st_err);
            chk("st_ready", i, 32'(bus.st_ready), 32'(vq[i].e_ready));
            chk("st_err",   i, 32'(bus.st_err),   32'(vq[i].e_err));
            chk("ld_stall", i, 32'(bus.ld_stall), 32'(vq[i].e_stall));
            chk("dm_we",    i, 32'(bus.dm_we),    32'(vq[i].e_we));
            chk("dm_be",    i, 32'(bus.dm_be),    32'(vq[i].e_be));
            chk("count",    i, 32'(bus.count),    32'(vq[i].e_count));
            chk("empty",    i, 32'(bus.empty),    32'(vq[i].e_count == 3'd0));
            if (vq[i].chk_a) chk("dm_a",    i, 32'(bus.dm_a), 32'(vq[i].e_a));
            if (vq[i].e_we)  chk("dm_wd",   i, bus.dm_wd,     vq[i].e_wd);
            if (vq[i].chk_ld) chk("ld_data", i, bus.ld_data,  vq[i].e_ld);
        end

        // --------------------------------------------------------------
        // Reset asserted while three stores are about to drain
        // --------------------------------------------------------------
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            drive(1, 2'b00, 13'(13'h040 + 4 * k), 32'hBEEF_0000 + k, 1, 13'h100);
            $display("rst-drain push %0d: addr=%03h", k, 13'h040 + 4 * k);
        end
        @(posedge clk);
        #1;
        drive(0, 2'b00, 13'h000, 32'h0, 0, 13'h000);
        #1;
        chk("pre_rst_dm_we", 100, 32'(bus.dm_we), 32'd1);
        chk("pre_rst_count", 100, 32'(bus.count), 32'd3);
        chk("pre_rst_dm_a",  100, 32'(bus.dm_a),  32'h10);
        #1;
        reset = 1'b1;
        #1;
        $display("rst-drain: reset asserted, we=%0b cnt=%0d", bus.dm_we, bus.count);
        chk("mid_rst_dm_we", 101, 32'(bus.dm_we), 32'd0);
        chk("mid_rst_count", 101, 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 101, 32'(bus.empty), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            drive(0, 2'b00, 13'h000, 32'h0, 1, 13'(13'h040 + 4 * k));
            #2;
            $display("rst-drain load %0d: a=%03h data=%08h stall=%0b", k, bus.dm_a, bus.ld_data, bus.ld_stall);
            chk("post_rst_stall", 110 + k, 32'(bus.ld_stall), 32'd0);
            chk("post_rst_dm_a",  110 + k, 32'(bus.dm_a),     32'h10 + k);
            chk("post_rst_ld",    110 + k, bus.ld_data,        32'h5A5A_0010 + k);
        end

        // --------------------------------------------------------------
        // Full buffer: push attempt in the same cycle as a pop
        // --------------------------------------------------------------
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk);
            #1;
            drive(1, 2'b00, 13'(13'h080 + 4 * k), 32'hF0 + k, 1, 13'h100);
            $display("full push %0d: addr=%03h", k, 13'h080 + 4 * k);
        end
        @(posedge clk);
        #1;
        drive(1, 2'b00, 13'h090, 32'hEE, 0, 13'h000);
        #2;
        chk("full_st_ready", 200, 32'(bus.st_ready), 32'd0);
        chk("full_count",    200, 32'(bus.count),    32'd4);
        chk("full_dm_we",    200, 32'(bus.dm_we),    32'd1);
        chk("full_dm_a",     200, 32'(bus.dm_a),     32'h20);
        @(posedge clk);
        #1;
        drive(0, 2'b00, 13'h000, 32'h0, 0, 13'h000);
        #2;
        $display("full: after pop cnt=%0d ready=%0b", bus.count, bus.st_ready);
        chk("after_pop_count", 201, 32'(bus.count),    32'd3);
        chk("after_pop_ready", 201, 32'(bus.st_ready), 32'd1);
        chk("after_pop_dm_a",  201, 32'(bus.dm_a),     32'h21);
        for (int k = 2; k < DEPTH; k++) begin
            @(posedge clk);
            #3;
            chk("drain_dm_a",  202 + k, 32'(bus.dm_a),  32'h20 + k);
            chk("drain_dm_wd", 202 + k, bus.dm_wd,      32'hF0 + k);
        end
        begin : wait_empty
            int budget;
            budget = 20;
            while (!bus.empty && budget > 0) begin
                @(posedge clk);
                #3;
                budget--;
            end
            chk("drain_done", 210, 32'(bus.empty), 32'd1);
        end
        // refused store never reached memory; an accepted one did
        @(posedge clk);
        #1;
        drive(0, 2'b00, 13'h000, 32'h0, 1, 13'h090);
        #2;
        chk("refused_word", 211, bus.ld_data, 32'h5A5A_0024);
        @(posedge clk);
        #1;
        drive(0, 2'b00, 13'h000, 32'h0, 1, 13'h080);
        #2;
        chk("accepted_word", 212, bus.ld_data, 32'h0000_00F0);
        @(posedge clk);
        #1;
        drive(0, 2'b00, 13'h000, 32'h0, 0, 13'h000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
